// File: rtl/usb_crc_rx_checker.sv
// USB receive CRC check-and-strip stage: forwards PID/payload bits, drops the trailing
// CRC5/CRC16 field and reports residue, length error and payload bit count at packet end.
module usb_crc_rx_checker #(
    parameter int unsigned PID_BITS = 8,
    parameter int unsigned CNT_W    = 16,
    parameter logic [15:0] POLY16   = 16'h8005,
    parameter logic [15:0] RES16    = 16'h800D,
    parameter logic [4:0]  POLY5    = 5'h05,
    parameter logic [4:0]  RES5     = 5'h0C
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             pkt_end,
    input  logic             crc_mode,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {StIdle, StPid, StBody, StDone} state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [15:0]        crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        dl_q, dl_d;
    logic               out_bit_q, out_bit_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               len_err_q, len_err_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    logic               start, active, accept, ending, mode_cur;
    logic [CNT_W-1:0]   w_len, cnt_base;
    logic [15:0]        crc_base, dl_base, crc16_nxt, crc5_nxt;
    logic               fb16, fb5, res_match;

    // First bit of a packet starts from a fresh CRC, counter and delay line.
    assign start    = (state_q == StIdle) && in_valid;
    assign active   = (state_q == StPid) || (state_q == StBody);
    assign accept   = start || (active && in_valid);
    assign ending   = active && pkt_end;
    assign mode_cur = start ? crc_mode : mode_q;
    assign w_len    = mode_cur ? CNT_W'(16) : CNT_W'(5);
    assign crc_base = start ? 16'hFFFF : crc_q;
    assign cnt_base = start ? '0 : cnt_q;
    assign dl_base  = start ? 16'h0000 : dl_q;

    assign fb16      = in_bit ^ crc_base[15];
    assign crc16_nxt = {crc_base[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'h0000);
    assign fb5       = in_bit ^ crc_base[4];
    assign crc5_nxt  = {11'h000, crc_base[3:0], 1'b0} ^ {11'h000, (fb5 ? POLY5 : 5'h00)};

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        crc_d       = crc_base;
        cnt_d       = cnt_base;
        dl_d        = dl_base;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        crc_ok_d    = crc_ok_q;
        len_err_d   = len_err_q;
        bit_count_d = bit_count_q;
        res_match   = 1'b0;

        if (start) begin
            mode_d    = crc_mode;
            crc_ok_d  = 1'b0;
            len_err_d = 1'b0;
            state_d   = (PID_BITS > 1) ? StPid : StBody;
        end

        if (accept) begin
            cnt_d = cnt_base + CNT_W'(1);
            dl_d  = {dl_base[14:0], in_bit};
            if (state_q == StBody) begin
                crc_d = mode_cur ? crc16_nxt : crc5_nxt;
            end
            // Tap at depth W; nothing leaves once the packet is ending.
            if (cnt_base >= w_len && !ending) begin
                out_valid_d = 1'b1;
                out_bit_d   = mode_cur ? dl_base[15] : dl_base[4];
            end
            if (state_q == StPid && cnt_d >= CNT_W'(PID_BITS)) begin
                state_d = StBody;
            end
        end

        if (ending) begin
            state_d     = StDone;
            done_d      = 1'b1;
            res_match   = mode_cur ? (crc_d == RES16) : (crc_d[4:0] == RES5);
            len_err_d   = cnt_d < (CNT_W'(PID_BITS) + w_len);
            crc_ok_d    = res_match && !len_err_d;
            bit_count_d = (cnt_d >= w_len) ? (cnt_d - w_len) : '0;
        end

        if (state_q == StDone) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            crc_q       <= 16'hFFFF;
            cnt_q       <= '0;
            dl_q        <= 16'h0000;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            len_err_q   <= 1'b0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            dl_q        <= dl_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            len_err_q   <= len_err_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign len_err   = len_err_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_usb_crc_rx_checker.sv
// Table-driven bench for usb_crc_rx_checker using standard USB token/data packets.
module tb_usb_crc_rx_checker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_bit, in_valid, pkt_end, crc_mode;
    logic        out_bit, out_valid, done, crc_ok, len_err;
    logic [15:0] bit_count;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic fwd[$];

    usb_crc_rx_checker dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .pkt_end   (pkt_end),
        .crc_mode  (crc_mode),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .done      (done),
        .crc_ok    (crc_ok),
        .len_err   (len_err),
        .bit_count (bit_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (out_valid) fwd.push_back(out_bit);
        if (done) done_pulses++;
    end

    typedef struct {
        string       name;
        logic [87:0] bits;
        int          nbits;
        logic        mode;
        int          gap_at;
        logic        coinc;
        int          flip;
        int          exp_cnt;
        logic        exp_ok;
        logic        exp_lerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // poke: drive a stray in_valid during the DONE cycle, which must be ignored.
    task automatic run_vec(input vec_t v, input logic poke);
        logic [87:0] b;
        int nbad;
        b = v.bits;
        if (v.flip >= 0) b[v.flip] = ~b[v.flip];
        fwd.delete();
        crc_mode = v.mode;
        for (int i = 0; i < v.nbits; i++) begin
            if (i == v.gap_at) begin
                @(negedge clock);
                in_valid = 1'b0;
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_bit   = b[i];
            pkt_end  = v.coinc && (i == v.nbits - 1);
        end
        if (!v.coinc) begin
            @(negedge clock);
            in_valid = 1'b0;
            pkt_end  = 1'b1;
        end
        @(negedge clock);
        pkt_end  = 1'b0;
        in_valid = poke;
        in_bit   = 1'b1;
        chk({v.name, " done"}, int'(done), 1);
        chk({v.name, " out_valid_after_end"}, int'(out_valid), 0);
        chk({v.name, " crc_ok"}, int'(crc_ok), int'(v.exp_ok));
        chk({v.name, " len_err"}, int'(len_err), int'(v.exp_lerr));
        chk({v.name, " bit_count"}, int'(bit_count), v.exp_cnt);
        @(negedge clock);
        in_valid = 1'b0;
        chk({v.name, " done_one_cycle"}, int'(done), 0);
        chk({v.name, " out_valid_late"}, int'(out_valid), 0);
        chk({v.name, " crc_ok_held"}, int'(crc_ok), int'(v.exp_ok));
        if (!v.coinc) begin
            nbad = 0;
            for (int i = 0; i < fwd.size() && i < 88; i++) if (fwd[i] !== b[i]) nbad++;
            chk({v.name, " fwd_len"}, fwd.size(), v.exp_cnt);
            chk({v.name, " fwd_bad_bits"}, nbad, 0);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses_before;
        vecs[0] = '{"setup", 88'h10_00_2D, 24, 1'b0, 10, 1'b0, -1, 19, 1'b1, 1'b0};
        vecs[1] = '{"zlp", 88'h00_00_C3, 24, 1'b1, -1, 1'b0, -1, 8, 1'b1, 1'b0};
        vecs[2] = '{"getdesc", 88'h94_DD_00_40_00_00_01_00_06_80_C3, 88, 1'b1, -1, 1'b0, -1,
                    72, 1'b1, 1'b0};
        vecs[3] = '{"getdesc_flip", 88'h94_DD_00_40_00_00_01_00_06_80_C3, 88, 1'b1, 40, 1'b0, 20,
                    72, 1'b0, 1'b0};
        vecs[4] = '{"short", 88'h80_C3, 10, 1'b1, -1, 1'b0, -1, 0, 1'b0, 1'b1};
        vecs[5] = '{"setup_coinc", 88'h10_00_2D, 24, 1'b0, -1, 1'b1, -1, 19, 1'b1, 1'b0};
        vecs[6] = '{"zlp_coinc", 88'h00_00_C3, 24, 1'b1, -1, 1'b1, -1, 8, 1'b1, 1'b0};
        vecs[7] = '{"getdesc_coinc", 88'h94_DD_00_40_00_00_01_00_06_80_C3, 88, 1'b1, -1, 1'b1,
                    -1, 72, 1'b1, 1'b0};

        reset_n  = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        pkt_end  = 1'b0;
        crc_mode = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset out_bit", int'(out_bit), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset done", int'(done), 0);
        chk("reset crc_ok", int'(crc_ok), 0);
        chk("reset len_err", int'(len_err), 0);
        chk("reset bit_count", int'(bit_count), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // pkt_end while idle: no done pulse, no state change.
        pulses_before = done_pulses;
        pkt_end = 1'b1;
        @(negedge clock);
        pkt_end = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle pkt_end no done", done_pulses - pulses_before, 0);

        run_vec(vecs[0], 1'b1);
        for (int i = 1; i < 8; i++) run_vec(vecs[i], 1'b0);

        // Reset in the middle of a data packet, then a clean packet.
        crc_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_bit   = vecs[2].bits[i];
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clock);
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset out_bit", int'(out_bit), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset crc_ok", int'(crc_ok), 0);
        chk("midreset len_err", int'(len_err), 0);
        chk("midreset bit_count", int'(bit_count), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        run_vec(vecs[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_crc_rx_checker.md
# usb_crc_rx_checker

Parametrised CRC check-and-strip stage for the USB receive path, sitting between the bit-unstuffer and the protocol handler. It replaces the fixed CRC16 receive decoder. It handles both token packets (CRC5) and data packets (CRC16), selected per packet. It forwards the PID and payload bits in order, drops the trailing CRC bits from the output stream, and reports the residue check and the payload length when the packet ends.

## Interface
Parameters:
- PID_BITS, 8: number of leading bits passed through but excluded from the CRC (the PID field).
- CNT_W, 16: width of the output bit counter; must hold 8 + 1023·8 bits.
- POLY16, 16'h8005: CRC16 generator polynomial.
- RES16, 16'h800D: required CRC16 residue.
- POLY5, 5'h05: CRC5 generator polynomial.
- RES5, 5'h0C: required CRC5 residue.

Ports:
- clock, input, 1: sole clock.
- reset_n, input, 1: synchronous, active-low reset.
- in_bit, input, 1: unstuffed data bit, LSB-first.
- in_valid, input, 1: in_bit valid this cycle (driven by the unstuffer's bs_sending).
- pkt_end, input, 1: one-cycle end-of-packet pulse (SE0/EOP detected upstream).
- crc_mode, input, 1: 0 = CRC5, 1 = CRC16; sampled only with the first bit of a packet.
- out_bit, output, 1: forwarded PID/payload bit.
- out_valid, output, 1: out_bit valid.
- done, output, 1: one-cycle pulse, packet finished.
- crc_ok, output, 1: residue matched; meaningful from done until the next packet starts.
- len_err, output, 1: packet ended before PID_BITS + W bits were received.
- bit_count, output, CNT_W: number of bits forwarded in the last packet.

## Operation
- W = 5 when the latched mode is 0, W = 16 when it is 1.
- FSM states: IDLE, PID, BODY, DONE.
  - IDLE → PID on the first in_valid. That cycle: latch crc_mode, preset crc to all ones, clear counters and the delay line, clear crc_ok and len_err.
  - PID → BODY after PID_BITS bits are accepted.
  - PID/BODY → DONE when pkt_end is sampled.
  - DONE → IDLE after exactly one cycle.
- CRC update applies only in BODY. For each accepted bit: fb = in_bit ^ crc[W-1]; crc = {crc[W-2:0],0} ^ (fb ? POLY : 0). Computation is in the low W bits of a 16-bit register.
- Delay line: a 16-deep shift register of accepted bits, tapped at depth W.
  - A bit is forwarded only once W newer bits have arrived.
  - At pkt_end the W bits still held (the CRC field) are discarded.
- in_valid and pkt_end in the same cycle: the bit is accepted first. It is included in the CRC, the residue compare and the length check, then the packet ends.
- Check at end: crc_ok = (next_crc == RES) and no len_err. len_err = 1 when total bits accepted < PID_BITS + W; in that case crc_ok = 0.
- bit_count = total bits accepted − W, saturating at 0; latched at pkt_end.
- in_valid while in DONE is ignored. pkt_end while in IDLE is ignored: no done pulse, no state change.
- Reset mid-packet: the FSM returns to IDLE and all partial state is discarded.

## Timing
- Reset values: out_bit 0, out_valid 0, done 0, crc_ok 0, len_err 0, bit_count 0, FSM IDLE, crc all ones.
- All outputs are registered.
- Latency: the bit accepted in cycle t, as the (k+W)-th bit, makes out_valid high in cycle t+1 carrying bit k.
- out_valid is never high in the cycle after pkt_end or later for the same packet.
- pkt_end sampled in cycle t → done = 1 in cycle t+1 only. crc_ok, len_err and bit_count are valid in cycle t+1 and held until the next packet's first bit.
- Back-to-back packets: the first bit of a new packet may arrive in the cycle done is high (the DONE state). It is ignored, so upstream must leave at least one idle cycle; the USB inter-packet gap guarantees this.
- Throughput: one bit per clock. in_valid gaps (unstuffed bits) stall the CRC and the delay line without loss.

## Test plan
- Token SETUP: bytes 2D 00 10, LSB-first, crc_mode 0, one in_valid gap inserted mid-packet → forwarded bits = 2D then 11 zero bits; bit_count 19, crc_ok 1, len_err 0, done one cycle after pkt_end.
- Data zero-length packet: bytes C3 00 00, crc_mode 1 → 8 bits forwarded (0xC3), bit_count 8, crc_ok 1.
- Data GET_DESCRIPTOR: bytes C3 80 06 00 01 00 00 40 00 DD 94, crc_mode 1 → output C3 80 06 00 01 00 00 40 00, bit_count 72, crc_ok 1. The same packet with one payload bit flipped → crc_ok 0.
- Short packet: 10 bits in crc_mode 1 → len_err 1, crc_ok 0, bit_count 0, no out_valid after the PID bits.
- Edge cases:
  - pkt_end coincident with the last in_valid → identical result to pkt_end one cycle later.
  - reset_n low mid-packet → all outputs 0 next cycle; the following packet checks correctly.
